// File: rtl/multi_timer_if.sv
// Bundle of the multi_timer control and status signals.
// The user side drives tick, enables, modes and delays; the timer drives status back.
interface multi_timer_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 10
);
    logic                      clk1kHz;
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       periodic;
    logic [CHANNELS*WIDTH-1:0] delayInMs;
    logic [CHANNELS-1:0]       timeout;
    logic [CHANNELS-1:0]       running;
    logic [CHANNELS*WIDTH-1:0] remaining;

    modport master (
        output clk1kHz, enable, periodic, delayInMs,
        input  timeout, running, remaining
    );

    modport slave (
        input  clk1kHz, enable, periodic, delayInMs,
        output timeout, running, remaining
    );
endinterface

// File: rtl/multi_timer.sv
// Multi-channel millisecond down-counter with one-shot and auto-reload modes.
// All channels share one edge-detected 1 kHz tick; every output comes straight from a register.
module multi_timer #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 10
) (
    input  logic          clk,
    input  logic          rst,
    multi_timer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic r_tick_q;
    logic w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_q <= 1'b0;
        end else begin
            r_tick_q <= bus.clk1kHz;
        end
    end

    assign w_tick = bus.clk1kHz & ~r_tick_q;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_t           r_state;
        logic [WIDTH-1:0] r_count;
        logic             r_timeout;
        logic             r_running;
        logic [WIDTH-1:0] w_delay;
        logic             w_expire;

        assign w_delay  = bus.delayInMs[gi*WIDTH +: WIDTH];
        // A zero count in RUN only arises from a zero periodic reload: expire every cycle.
        assign w_expire = (r_count == '0) || (w_tick && (r_count == WIDTH'(1)));

        always_ff @(posedge clk) begin
            if (rst || !bus.enable[gi]) begin
                r_state   <= ST_IDLE;
                r_count   <= '0;
                r_timeout <= 1'b0;
                r_running <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_count <= w_delay;
                        if (w_delay != '0) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                            r_timeout <= 1'b0;
                        end else if (bus.periodic[gi]) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                            r_timeout <= 1'b1;
                        end else begin
                            r_state   <= ST_DONE;
                            r_running <= 1'b0;
                            r_timeout <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_expire) begin
                            r_timeout <= 1'b1;
                            if (bus.periodic[gi]) begin
                                r_count <= w_delay;
                            end else begin
                                r_count   <= '0;
                                r_state   <= ST_DONE;
                                r_running <= 1'b0;
                            end
                        end else begin
                            r_timeout <= 1'b0;
                            if (w_tick) begin
                                r_count <= r_count - WIDTH'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        r_count   <= '0;
                        r_timeout <= 1'b1;
                        r_running <= 1'b0;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_count   <= '0;
                        r_timeout <= 1'b0;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end

        assign bus.timeout[gi]                   = r_timeout;
        assign bus.running[gi]                   = r_running;
        assign bus.remaining[gi*WIDTH +: WIDTH]  = r_count;
    end
endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: a tick-counting reference model checked every cycle,
// plus hand-computed expectations for load, expiry, disable, reset and width corner cases.
module tb_multi_timer;
    localparam int CH = 4;
    localparam int W  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic k1  = 1'b0;
    bit   tick_en = 1'b0;

    always #5 clk = ~clk;

    multi_timer_if #(.CHANNELS(CH), .WIDTH(W)) tbif ();

    multi_timer #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tbif)
    );

    // 1 kHz stand-in: toggles every clk cycle, so a tick strobe every second cycle.
    always @(negedge clk) if (tick_en) k1 = ~k1;
    assign tbif.clk1kHz = k1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [W-1:0] rem(input int c);
        return tbif.remaining[c*W +: W];
    endfunction

    // Reference model: a captured delay and a count of ticks consumed since capture.
    bit          m_prev_k;
    bit          m_on    [CH];
    bit          m_fired [CH];
    bit          m_pulse [CH];
    int unsigned m_cap   [CH];
    int unsigned m_ticks [CH];

    always @(posedge clk) begin
        bit          tk;
        int unsigned d;
        tk = tbif.clk1kHz && !m_prev_k;
        if (rst) begin
            m_prev_k = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_on[c] = 0; m_fired[c] = 0; m_pulse[c] = 0; m_cap[c] = 0; m_ticks[c] = 0;
            end
        end else begin
            m_prev_k = tbif.clk1kHz;
            for (int c = 0; c < CH; c++) begin
                d = tbif.delayInMs[c*W +: W];
                if (!tbif.enable[c]) begin
                    m_on[c] = 0; m_fired[c] = 0; m_pulse[c] = 0; m_cap[c] = 0; m_ticks[c] = 0;
                end else if (!m_on[c]) begin
                    m_on[c]    = 1;
                    m_cap[c]   = d;
                    m_ticks[c] = 0;
                    m_pulse[c] = (d == 0);
                    m_fired[c] = (d == 0) && !tbif.periodic[c];
                end else if (!m_fired[c]) begin
                    m_pulse[c] = 0;
                    if (m_cap[c] == 0 || (tk && m_ticks[c] + 1 == m_cap[c])) begin
                        if (tbif.periodic[c]) begin
                            m_cap[c]   = d;
                            m_ticks[c] = 0;
                            m_pulse[c] = 1;
                        end else begin
                            m_fired[c] = 1;
                        end
                    end else if (tk) begin
                        m_ticks[c]++;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        logic [CH-1:0]   e_to;
        logic [CH-1:0]   e_run;
        logic [CH*W-1:0] e_rem;
        #1;
        for (int c = 0; c < CH; c++) begin
            e_to[c]          = m_fired[c] || m_pulse[c];
            e_run[c]         = m_on[c] && !m_fired[c];
            e_rem[c*W +: W]  = m_fired[c] ? W'(0) : W'(m_cap[c] - m_ticks[c]);
        end
        check("model_timeout", tbif.timeout, e_to);
        check("model_running", tbif.running, e_run);
        check("model_remaining", tbif.remaining, e_rem);
    end

    initial begin
        int n;
        int pulses;
        tbif.enable    = '0;
        tbif.periodic  = '0;
        tbif.delayInMs = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_timeout", tbif.timeout, 0);
        check("reset_running", tbif.running, 0);
        check("reset_remaining", tbif.remaining, 0);

        @(negedge clk);
        rst     = 1'b0;
        tick_en = 1'b1;

        // One-shot 10, one-shot 0, one-shot 10 (delay changed mid-run), periodic 3.
        @(negedge clk);
        tbif.delayInMs[0*W +: W] = 10'd10;
        tbif.delayInMs[1*W +: W] = 10'd0;
        tbif.delayInMs[2*W +: W] = 10'd10;
        tbif.delayInMs[3*W +: W] = 10'd3;
        tbif.periodic = 4'b1000;
        tbif.enable   = 4'b1111;
        @(posedge clk); #1;
        check("load_running", tbif.running, 4'b1101);
        check("load_timeout", tbif.timeout, 4'b0010);
        check("load_rem0", rem(0), 10);

        n = 0;
        while (!tbif.timeout[0] && n < 40) begin
            @(negedge clk);
            if (n == 6) begin
                tbif.delayInMs[2*W +: W] = 10'd0;
                tbif.delayInMs[3*W +: W] = 10'd5;
            end
            @(posedge clk); #1;
            n++;
        end
        check_range("oneshot_latency_cycles", n, 19, 20);
        check("ch2_expires_with_ch0", tbif.timeout[2], 1);

        repeat (5) @(posedge clk);
        #1;
        check("oneshot_holds_timeout", tbif.timeout[0], 1);
        check("oneshot_done_rem0", rem(0), 0);

        @(negedge clk);
        tbif.enable[0] = 1'b0;
        @(posedge clk); #1;
        check("disable_timeout0", tbif.timeout[0], 0);
        check("disable_running0", tbif.running[0], 0);
        check("disable_rem0", rem(0), 0);

        // Periodic with zero delay on channel 1.
        @(negedge clk);
        tbif.enable[1] = 1'b0;
        @(negedge clk);
        tbif.periodic[1] = 1'b1;
        tbif.enable[1]   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("per0_timeout", tbif.timeout[1], 1);
            check("per0_running", tbif.running[1], 1);
            check("per0_rem", rem(1), 0);
        end

        // Channel 3 now reloads 5 ticks: one pulse per 10 cycles.
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (tbif.timeout[3]) pulses++;
        end
        check("ch3_pulses_in_40_cycles", pulses, 4);

        // Reset mid-run with enables held high.
        @(negedge clk);
        tbif.enable = '0;
        @(negedge clk);
        for (int c = 0; c < CH; c++) tbif.delayInMs[c*W +: W] = 10'd10;
        tbif.periodic = '0;
        tbif.enable   = 4'b1111;
        @(posedge clk); #1;
        n = 0;
        while (rem(0) != 4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_wait_rem4", rem(0), 4);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_timeout", tbif.timeout, 0);
        check("midrst_running", tbif.running, 0);
        check("midrst_remaining", tbif.remaining, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reload_running", tbif.running, 4'b1111);
        check("reload_remaining", tbif.remaining, {4{10'd10}});

        // Maximum delay on two channels together; channel 2 disabled mid-run.
        @(negedge clk);
        tbif.enable = '0;
        tbif.delayInMs[0*W +: W] = 10'd1023;
        tbif.delayInMs[1*W +: W] = 10'd1023;
        tbif.delayInMs[2*W +: W] = 10'd500;
        tbif.delayInMs[3*W +: W] = 10'd0;
        @(negedge clk);
        tbif.enable = 4'b0111;
        @(posedge clk); #1;
        check("max_load_rem1", rem(1), 1023);
        n = 0;
        while (!tbif.timeout[0] && n < 2100) begin
            @(negedge clk);
            if (n == 200) tbif.enable[2] = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check_range("max_latency_cycles", n, 2045, 2046);
        check("max_ch1_same_cycle", tbif.timeout[1], 1);
        check("max_ch1_rem", rem(1), 0);
        check("max_ch2_disabled", tbif.running[2], 0);

        @(negedge clk);
        tbif.enable = '0;
        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel millisecond timer: the next generation of the single-channel `timer`. It provides CHANNELS independent down-counters of configurable WIDTH, each with one-shot or periodic mode. All channels share one 1 kHz tick, which the block edge-detects in the `clk` domain. The block sits beside the clock dividers and serves LED blink, debounce and protocol timeout logic that would otherwise instantiate several `timer` copies.

## Interface
- CHANNELS, 4, number of independent timer channels (1..16)
- WIDTH, 10, width of each delay/counter in ms ticks (max delay 2^WIDTH-1)

- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- clk1kHz  input  1  1 kHz square wave, synchronous to clk; its rising edge is the count tick
- enable  input  CHANNELS  per-channel run request (level)
- periodic  input  CHANNELS  per-channel mode: 0 = one-shot, 1 = auto-reload
- delayInMs  input  CHANNELS*WIDTH  per-channel delay; channel i uses bits [i*WIDTH +: WIDTH]
- timeout  output  CHANNELS  one-shot: level until disabled; periodic: 1-cycle pulse per period
- running  output  CHANNELS  channel is in RUN state
- remaining  output  CHANNELS*WIDTH  per-channel current counter value

## Operation
- Tick: register `tick_q <= clk1kHz`. `tick = clk1kHz & ~tick_q` is a one-cycle strobe. Reset clears tick_q.
- Each channel has states IDLE, RUN, DONE. Reset value: IDLE, counter 0, timeout 0, running 0, remaining 0.
- enable low in any state: go to IDLE next cycle, clear counter and timeout. This has priority over everything except rst.
- IDLE with enable high:
  - load counter with delayInMs.
  - If the loaded value is non-zero, go to RUN.
  - If it is 0: one-shot goes to DONE with timeout=1; periodic goes to RUN with a timeout pulse (see below).
- RUN:
  - On tick, decrement the counter.
  - When counter==1 and tick: the counter becomes 0 and the channel expires.
  - Ticks in the load cycle are ignored, so counting starts with the next tick.
- Expiry, one-shot: go to DONE and set timeout=1. DONE holds timeout=1 and counter=0 until enable falls.
- Expiry, periodic:
  - Reload counter from the current delayInMs, stay in RUN, and pulse timeout for exactly one cycle.
  - If the reload value is 0, timeout asserts every cycle while enabled; the counter stays 0.
- Delay capture: delayInMs is sampled only at load or reload. Changes during RUN take effect at the next reload only.
- Arithmetic: the counter is unsigned WIDTH bits and never decrements below 0, so there is no wrap-around. Max delay 2^WIDTH-1 loads and counts normally.
- Channels are fully independent. Simultaneous expiries, loads and disables on different channels are all processed in the same cycle.
- running=1 exactly in RUN. remaining mirrors the counter register.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Load latency: enable sampled high at edge E gives running=1 (or, for delay 0, timeout=1) after edge E.
- Expiry latency: timeout rises after the clk edge that samples the D-th tick strobe following the load cycle. With clk1kHz toggling every clk cycle, that is 2·D clk cycles ±1 after the load.
- Disable latency: enable sampled low at edge E gives timeout=0, running=0 and remaining=0 after E.
- rst sampled high at any edge returns all channels to IDLE and all outputs to 0 after that edge, regardless of enable.
- If enable is still high when rst falls, the channel reloads on the first edge with rst low.

## Test plan
- One-shot: CH0 delay=10, periodic=0, enable rises → running=1 next cycle; remaining counts 10→0; timeout rises after the 10th tick and stays high. Then enable=0 → timeout=0 the following cycle.
- Delay 0 and mid-run change: CH1 delay=0 one-shot → timeout=1 one cycle after enable is sampled. CH2 delay=10, with delay changed to 0 after 3 ticks → timeout still after the 10th tick.
- Periodic: CH3 delay=3, periodic=1 → a 1-cycle timeout pulse every 3 ticks (6 clk cycles). Changing delay to 5 mid-period → current period still 3, following periods 5.
- Periodic with delay 0: timeout high every cycle while enabled; remaining=0; running=1.
- Reset mid-run: all channels running, rst pulsed for 1 cycle at remaining=4 → all outputs 0 next cycle. With enable still high, channels reload the full delay the cycle after rst falls.
- Concurrency and width: WIDTH=10, CH0 delay=1023 and CH1 delay=1023 enabled in the same cycle → both time out in the same cycle after 1023 ticks, with no wrap. CH2 is disabled mid-run without disturbing CH0 or CH1.
